lc4_div_seq: RTL
================

// Module: lc4_div_seq
// PURPOSE
//  Multi-cycle 16-bit unsigned divider sequencer for the LC4 DIV/MOD path.
//  Computes one quotient bit per cycle by restoring division, routing every
//  trial subtraction through a single shared cla16 instance (a=partial rem,
//  b=~divisor, cin=1). Valid/ready on both sides; sits between decode/issue
//  and writeback of the multi-cycle LC4 pipeline.
// PARAMETERS
//  DIV0_QUOT  16'h0000  quotient returned when divisor == 0
//  DIV0_REM   16'h0000  remainder returned when divisor == 0
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  dividend   in   16  unsigned dividend, sampled on accept
//  divisor    in   16  unsigned divisor, sampled on accept
//  out_valid  out  1   quotient/remainder valid (high only in DONE)
//  out_ready  in   1   consumer takes result
//  quotient   out  16  result quotient, stable while out_valid
//  remainder  out  16  result remainder, stable while out_valid
//  busy       out  1   high in CALC or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; quotient=0, remainder=0,
//   out_valid=0, busy=0, in_ready=1 once rst_n released; step count=0.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept = in_valid & in_ready at edge T: latch divisor,
//   Q<=dividend, R<=0, cnt<=15. divisor==0 -> DONE directly (Q=DIV0_QUOT,
//   R=DIV0_REM), out_valid at T+1. Else -> CALC.
//  CALC (one step/cycle): S = {R,Q[15]} (17 bits); cla16 a=S[15:0],
//   b=~divisor, cin=1; cout15 = g15 | p15&(a15^b15^sum15) of the operands.
//   ge = S[16] | cout15. R<= ge ? sum : S[15:0]; Q<={Q[14:0],ge}.
//   cnt==0 -> DONE else cnt<=cnt-1. 16 CALC cycles; out_valid at T+17.
//  DONE: out_valid=1, quotient=Q, remainder=R held stable; leave to IDLE on
//   out_valid & out_ready (same edge clears out_valid). in_ready stays 0 in
//   DONE: new operands accepted no earlier than the cycle after handoff.
//  in_valid while busy: ignored, not queued; source must hold per handshake.
//  out_ready with out_valid=0: no effect. dividend<divisor: q=0,r=dividend.
//  Max case 16'hFFFF/16'h0001 -> q=FFFF r=0 (no overflow; S[16] path needed
//   when divisor>16'h8000).
//  rst_n asserted mid-CALC/DONE: operation discarded, no out_valid, IDLE.
//  Exactly one cla16 instance; no other 16-bit adder/comparator in datapath
//   except under the macro below.
// CONFIGURATION
//  LC4_DIV_EARLY_OUT_EN defined: first CALC cycle (cnt==15) also uses the
//   shared cla16 with a=dividend, b=~divisor, cin=1; if no carry-out
//   (dividend<divisor) -> DONE with q=0, r=dividend, out_valid at T+2.
//   Dividend==0 likewise exits at T+2 with q=0,r=0.
//  Undefined: every nonzero-divisor op takes full 16 CALC cycles (T+17).
// TESTING
//  100/7 accepted at T -> out_valid at T+17, quotient=14, remainder=2.
//  FFFF/0001 -> q=FFFF r=0000; FFFF/8001 -> q=0001 r=7FFE (S[16] path).
//  1234/0000 -> out_valid at T+1, q=DIV0_QUOT r=DIV0_REM; busy 1 cycle.
//  out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, then
//   handoff; next accept no earlier than following cycle.
//  rst_n pulsed low at CALC step 8 -> out_valid never rises, in_ready=1
//   after release; next op 0x0040/0x0004 -> q=0x0010 r=0.
//  With LC4_DIV_EARLY_OUT_EN: 0003/0009 -> out_valid at T+2, q=0 r=3;
//   without -> T+17, same values.

Source files
------------

// File: rtl/lc4_div_seq.sv
// Sequential 16-bit unsigned restoring divider for the LC4 DIV/MOD path, one quotient bit per cycle.
// Optional feature macro: LC4_DIV_EARLY_OUT_EN (first CALC cycle checks dividend < divisor and exits early).

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    logic [15:0] g, p, c;
    logic [2:0]  grp_g, grp_p;
    logic [3:0]  grp_c;

    // Four 4-bit groups; group carries come from lookahead, bit carries ripple inside each group.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 3; k++) begin
            grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = cin;
        for (int k = 1; k < 4; k++) begin
            grp_c[k] = grp_g[k-1] | (grp_p[k-1] & grp_c[k-1]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = grp_c[k];
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
        end
        sum = p ^ c;
    end
endmodule

module lc4_div_seq #(
    parameter logic [15:0] DIV0_QUOT = 16'h0000,
    parameter logic [15:0] DIV0_REM  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] quot_q, quot_d, rem_q, rem_d, dsor_q, dsor_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] cla_a, cla_b, cla_sum;
    logic        accept, cout15, ge, early_chk;

    assign accept = (state_q == S_IDLE) && in_valid;

`ifdef LC4_DIV_EARLY_OUT_EN
    logic chk_q, chk_d;

    // High only during the first CALC cycle, when the adder compares the raw dividend instead.
    always_comb chk_d = accept && (divisor != 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_q <= 1'b0;
        else        chk_q <= chk_d;
    end

    assign early_chk = chk_q;
`else
    assign early_chk = 1'b0;
`endif

    // Trial subtraction S[15:0] - divisor; the shifted-out R[15] is S[16] and forces ge.
    assign cla_a = early_chk ? quot_q : {rem_q[14:0], quot_q[15]};
    assign cla_b = ~dsor_q;

    cla16 u_cla (
        .a   (cla_a),
        .b   (cla_b),
        .cin (1'b1),
        .sum (cla_sum)
    );

    assign cout15 = (cla_a[15] & cla_b[15])
                  | ((cla_a[15] ^ cla_b[15]) & (cla_a[15] ^ cla_b[15] ^ cla_sum[15]));
    assign ge     = rem_q[15] | cout15;

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dsor_d  = dsor_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dsor_d = divisor;
                    cnt_d  = 4'd15;
                    if (divisor == 16'h0000) begin
                        quot_d  = DIV0_QUOT;
                        rem_d   = DIV0_REM;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = dividend;
                        rem_d   = 16'h0000;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (early_chk) begin
                    if (!cout15) begin
                        quot_d  = 16'h0000;
                        rem_d   = quot_q;
                        state_d = S_DONE;
                    end
                end else begin
                    rem_d  = ge ? cla_sum : cla_a;
                    quot_d = {quot_q[14:0], ge};
                    if (cnt_q == 4'd0) state_d = S_DONE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            quot_q  <= 16'h0000;
            rem_q   <= 16'h0000;
            dsor_q  <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dsor_q  <= dsor_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
endmodule
